alu_arbiter: RTL and testbench

Shares one 32-bit ALU between two requesters (e.g. the execute stage and the address-generation unit) using valid/ready handshakes. Grants one request per cycle, evaluates it in a combinational ALU core, and registers the result into a single-entry output buffer tagged with the winning port. Sits between the requesters and the writeback/consumer logic; per-port accept counters support performance observation.

---
 rtl/alu_arb_pkg.sv | 13 +
 rtl/alu_arbiter_alu_core.sv | 28 ++
 rtl/alu_arbiter.sv | 118 +++++++++++
 tb/tb_alu_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared opcode encodings and default widths for the two-port ALU arbiter.
package alu_arb_pkg;

  localparam int ALU_W         = 32;
  localparam int CNT_W_DEFAULT = 16;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

endpackage

// File: rtl/alu_arbiter_alu_core.sv
// Purely combinational ALU: AND/OR/ADD/SUB/unsigned SLT; unknown opcodes yield zero.
module alu_core
  import alu_arb_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic [W-1:0] z,
  output logic         zero
);

  always_comb begin
    z = '0;
    case (op)
      OP_AND:  z = a & b;
      OP_OR:   z = a | b;
      OP_ADD:  z = a + b;
      OP_SUB:  z = a - b;
      OP_SLT:  z = {{(W-1){1'b0}}, (a < b)};
      default: z = '0;
    endcase
  end

  assign zero = (z == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Two-port valid/ready arbiter sharing one ALU, with a single-entry tagged result buffer.
// Define ALU_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 wins every tie.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int W     = ALU_W,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [W-1:0]     req0_a,
  input  logic [W-1:0]     req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [W-1:0]     req1_a,
  input  logic [W-1:0]     req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_z,
  output logic             rsp_zero,
  output logic             rsp_id,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic         space;
  logic         tie_gnt1;
  logic         gnt1;
  logic         accept;
  logic [W-1:0] a_mux;
  logic [W-1:0] b_mux;
  logic [2:0]   op_mux;
  logic [W-1:0] z_next;
  logic         zero_next;
  logic [1:0]   acc_vec;

  logic         rsp_valid_reg;
  logic [W-1:0] rsp_z_reg;
  logic         rsp_zero_reg;
  logic         rsp_id_reg;

`ifdef ALU_ARB_RR_EN
  logic last_grant_reg;

  // Only a real accept moves the pointer, so a stalled tie keeps its winner.
  always_ff @(posedge clk) begin
    if (!rst_n)
      last_grant_reg <= 1'b1;
    else if (accept)
      last_grant_reg <= gnt1;
  end

  assign tie_gnt1 = ~last_grant_reg;
`else
  assign tie_gnt1 = 1'b0;
`endif

  assign space  = !rsp_valid_reg || rsp_ready;
  assign gnt1   = (req0_valid && req1_valid) ? tie_gnt1 : req1_valid;
  assign accept = rst_n && space && (req0_valid || req1_valid);

  assign req0_ready = accept && !gnt1;
  assign req1_ready = accept && gnt1;
  assign acc_vec    = {req1_ready, req0_ready};

  assign a_mux  = gnt1 ? req1_a  : req0_a;
  assign b_mux  = gnt1 ? req1_b  : req0_b;
  assign op_mux = gnt1 ? req1_op : req0_op;

  alu_core #(.W(W)) u_alu_core (
    .a    (a_mux),
    .b    (b_mux),
    .op   (op_mux),
    .z    (z_next),
    .zero (zero_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_reg <= 1'b0;
      rsp_z_reg     <= '0;
      rsp_zero_reg  <= 1'b1;
      rsp_id_reg    <= 1'b0;
    end else if (accept) begin
      rsp_valid_reg <= 1'b1;
      rsp_z_reg     <= z_next;
      rsp_zero_reg  <= zero_next;
      rsp_id_reg    <= gnt1;
    end else if (rsp_ready) begin
      rsp_valid_reg <= 1'b0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (!rst_n)
          cnt_reg <= '0;
        else if (acc_vec[gi])
          cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  endgenerate

  assign cnt0      = g_cnt[0].cnt_reg;
  assign cnt1      = g_cnt[1].cnt_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_z     = rsp_z_reg;
  assign rsp_zero  = rsp_zero_reg;
  assign rsp_id    = rsp_id_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized, model-checked bench for alu_arbiter (follows ALU_ARB_RR_EN when defined).
module tb_alu_arbiter;

  localparam int W     = 32;
  localparam int CNT_W = 4;
`ifdef ALU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             req0_valid, req0_ready;
  logic [W-1:0]     req0_a, req0_b;
  logic [2:0]       req0_op;
  logic             req1_valid, req1_ready;
  logic [W-1:0]     req1_a, req1_b;
  logic [2:0]       req1_op;
  logic             rsp_valid, rsp_ready;
  logic [W-1:0]     rsp_z;
  logic             rsp_zero, rsp_id;
  logic [CNT_W-1:0] cnt0, cnt1;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit          m_valid;
  logic [31:0] m_z;
  bit          m_id;
  int          m_cnt0, m_cnt1;
  bit          m_last;
  bit          e_rdy0, e_rdy1;

  alu_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_z      (rsp_z),
    .rsp_zero   (rsp_zero),
    .rsp_id     (rsp_id),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive0(input bit v, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op);
    req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
  endtask

  task automatic drive1(input bit v, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op);
    req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
  endtask

  // Let inputs settle, then decide who the rules say should be accepted this cycle.
  task automatic predict();
    bit space;
    bit pick1;
    #1;
    space = !m_valid || rsp_ready;
    if (req0_valid && req1_valid)
      pick1 = RR ? (m_last == 1'b0) : 1'b0;
    else
      pick1 = req1_valid;
    e_rdy0 = rst_n && space && req0_valid && !pick1;
    e_rdy1 = rst_n && space && req1_valid && pick1;
  endtask

  // Advance one clock and apply the accepted transaction (or reset) to the model.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 0; m_z = 0; m_id = 0; m_cnt0 = 0; m_cnt1 = 0; m_last = 1;
    end else if (e_rdy0) begin
      m_valid = 1; m_z = alu_ref(req0_a, req0_b, req0_op); m_id = 0;
      m_cnt0 = (m_cnt0 + 1) % (1 << CNT_W); m_last = 0;
    end else if (e_rdy1) begin
      m_valid = 1; m_z = alu_ref(req1_a, req1_b, req1_op); m_id = 1;
      m_cnt1 = (m_cnt1 + 1) % (1 << CNT_W); m_last = 1;
    end else if (rsp_ready) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 0;
    drive0(0, 0, 0, 0);
    drive1(0, 0, 0, 0);
    repeat (n) begin
      predict();
      tick();
    end
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    rsp_ready = 1;
    drive0(1, 32'h11, 32'h22, 3'b010);
    drive1(1, 32'h33, 32'h44, 3'b001);
    repeat (2) begin
      predict();
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready);
      end
      tick();
    end
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid);
    end
    checks++;
    if (rsp_zero !== 1'b1 || rsp_z !== 32'd0 || rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp: got z=%h zero=%b id=%b expected z=0 zero=1 id=0",
               rsp_z, rsp_zero, rsp_id);
    end
    checks++;
    if (cnt0 !== 4'd0 || cnt1 !== 4'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", cnt0, cnt1);
    end
    drive0(0, 0, 0, 0);
    drive1(0, 0, 0, 0);
    rst_n = 1;
  endtask

  task automatic test_add_wrap();
    rsp_ready = 1;
    drive0(1, 32'hFFFF_FFFF, 32'd1, 3'b010);
    drive1(0, 0, 0, 0);
    predict();
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL add_ready: got %b%b expected 10", req0_ready, req1_ready);
    end
    tick();
    drive0(0, 0, 0, 0);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_z !== 32'd0 || rsp_zero !== 1'b1 || rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL add_wrap: got v=%b z=%h zero=%b id=%b expected v=1 z=0 zero=1 id=0",
               rsp_valid, rsp_z, rsp_zero, rsp_id);
    end
    checks++;
    if (cnt0 !== 4'd1) begin
      errors++; $display("FAIL add_cnt0: got %0d expected 1", cnt0);
    end
    predict();
    tick();
  endtask

  task automatic test_arbitration();
    bit          exp_id;
    logic [31:0] exp_z;
    do_reset(1);
    rsp_ready = 1;
    drive0(1, 32'd5, 32'd7, 3'b110);
    drive1(1, 32'd3, 32'd9, 3'b111);
    for (int i = 0; i < 6; i++) begin
      predict();
      checks++;
      if (req0_ready !== e_rdy0 || req1_ready !== e_rdy1) begin
        errors++;
        $display("FAIL arb_ready[%0d]: got %b%b expected %b%b", i, req0_ready, req1_ready,
                 e_rdy0, e_rdy1);
      end
      tick();
      exp_id = RR ? bit'(i % 2) : 1'b0;
      exp_z  = exp_id ? 32'd1 : 32'hFFFF_FFFE;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_z !== exp_z) begin
        errors++;
        $display("FAIL arb_result[%0d]: got v=%b id=%b z=%h expected v=1 id=%b z=%h",
                 i, rsp_valid, rsp_id, rsp_z, exp_id, exp_z);
      end
    end
    checks++;
    if (cnt1 !== (RR ? 4'd3 : 4'd0)) begin
      errors++; $display("FAIL arb_cnt1: got %0d expected %0d", cnt1, RR ? 3 : 0);
    end
    drive0(0, 0, 0, 0);
    drive1(0, 0, 0, 0);
    predict();
    tick();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1;
    drive0(1, 32'h0000_F0F0, 32'h0000_FF00, 3'b000);
    drive1(0, 0, 0, 0);
    predict();
    tick();
    drive0(0, 0, 0, 0);
    drive1(1, 32'h0000_0100, 32'h0000_0023, 3'b010);
    rsp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      predict();
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_ready[%0d]: got %b%b expected 00", i, req0_ready, req1_ready);
      end
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_z !== 32'h0000_F000 || rsp_id !== 1'b0 || rsp_zero !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b z=%h id=%b expected v=1 z=0000f000 id=0",
                 i, rsp_valid, rsp_z, rsp_id);
      end
    end
    rsp_ready = 1;
    predict();
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready: got %b expected 1", req1_ready);
    end
    tick();
    drive1(0, 0, 0, 0);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_z !== 32'h0000_0123) begin
      errors++;
      $display("FAIL bp_swap: got v=%b id=%b z=%h expected v=1 id=1 z=00000123",
               rsp_valid, rsp_id, rsp_z);
    end
    predict();
    tick();
  endtask

  task automatic test_illegal_op();
    int prev;
    prev = m_cnt1;
    rsp_ready = 1;
    drive0(0, 0, 0, 0);
    drive1(1, 32'h1234, 32'h1234, 3'b011);
    predict();
    tick();
    drive1(0, 0, 0, 0);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_z !== 32'd0 || rsp_zero !== 1'b1 || rsp_id !== 1'b1) begin
      errors++;
      $display("FAIL illegal_op: got v=%b z=%h zero=%b id=%b expected v=1 z=0 zero=1 id=1",
               rsp_valid, rsp_z, rsp_zero, rsp_id);
    end
    checks++;
    if (cnt1 !== 4'((prev + 1) % 16)) begin
      errors++; $display("FAIL illegal_cnt1: got %0d expected %0d", cnt1, (prev + 1) % 16);
    end
  endtask

  task automatic test_random();
    bit          hold0, hold1;
    logic [2:0]  ops [8];
    ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111, 3'b011, 3'b100, 3'b101};
    hold0 = 0;
    hold1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (!hold0)
        drive0($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom(),
               $urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom(), ops[$urandom_range(0, 7)]);
      if (!hold1)
        drive1($urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom(),
               $urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom(), ops[$urandom_range(0, 7)]);
      rsp_ready = ($urandom_range(0, 3) != 0);
      predict();
      checks++;
      if (req0_ready !== e_rdy0 || req1_ready !== e_rdy1) begin
        errors++;
        $display("FAIL rand_ready[%0d]: got %b%b expected %b%b", i, req0_ready, req1_ready,
                 e_rdy0, e_rdy1);
      end
      hold0 = req0_valid && !e_rdy0;
      hold1 = req1_valid && !e_rdy1;
      tick();
      checks++;
      if (rsp_valid !== m_valid) begin
        errors++; $display("FAIL rand_valid[%0d]: got %b expected %b", i, rsp_valid, m_valid);
      end
      if (m_valid) begin
        checks++;
        if (rsp_z !== m_z || rsp_zero !== (m_z == 32'd0) || rsp_id !== m_id) begin
          errors++;
          $display("FAIL rand_rsp[%0d]: got z=%h zero=%b id=%b expected z=%h zero=%b id=%b",
                   i, rsp_z, rsp_zero, rsp_id, m_z, (m_z == 32'd0), m_id);
        end
      end
      checks++;
      if (cnt0 !== 4'(m_cnt0) || cnt1 !== 4'(m_cnt1)) begin
        errors++;
        $display("FAIL rand_cnt[%0d]: got %0d/%0d expected %0d/%0d", i, cnt0, cnt1, m_cnt0, m_cnt1);
      end
    end
    drive0(0, 0, 0, 0);
    drive1(0, 0, 0, 0);
    rsp_ready = 1;
    predict();
    tick();
  endtask

  task automatic test_counter_wrap();
    do_reset(1);
    rsp_ready = 1;
    for (int i = 0; i < 16; i++) begin
      drive0(1, $urandom(), $urandom(), 3'b001);
      predict();
      checks++;
      if (req0_ready !== 1'b1) begin
        errors++; $display("FAIL wrap_ready[%0d]: got %b expected 1", i, req0_ready);
      end
      tick();
    end
    checks++;
    if (cnt0 !== 4'd0 || cnt1 !== 4'd0) begin
      errors++; $display("FAIL wrap_cnt: got %0d/%0d expected 0/0", cnt0, cnt1);
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL wrap_pending: got %b expected 1", rsp_valid);
    end
    rst_n = 0;
    rsp_ready = 0;
    predict();
    checks++;
    if (req0_ready !== 1'b0) begin
      errors++; $display("FAIL midreset_ready: got %b expected 0", req0_ready);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_zero !== 1'b1) begin
      errors++;
      $display("FAIL midreset_drop: got v=%b zero=%b expected v=0 zero=1", rsp_valid, rsp_zero);
    end
    rst_n = 1;
    drive0(0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 0;
    rsp_ready = 0;
    drive0(0, 0, 0, 0);
    drive1(0, 0, 0, 0);
    m_valid = 0; m_z = 0; m_id = 0; m_cnt0 = 0; m_cnt1 = 0; m_last = 1;
    e_rdy0 = 0; e_rdy1 = 0;
    test_reset();
    test_add_wrap();
    test_arbitration();
    test_backpressure();
    test_illegal_op();
    test_random();
    test_counter_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
